scan_load_ctrl: RTL and testbench
=================================

SCAN_LOAD_CTRL -- requirements
Module: scan_load_ctrl

Interface
REQ-001 Parameter CHAIN_LEN, default 16: number of scan-mux flops in the driven chain; legal range 2..64.
REQ-002 Parameter CNT_W, default 6: shift-counter width; SHALL satisfy 2^CNT_W > CHAIN_LEN.
REQ-003 CK  input  1: single clock; all state updates on the rising edge.
REQ-004 CD  input  1: reset, asynchronous, active-high.
REQ-005 START  input  1: request one load sequence; sampled at rising CK.
REQ-006 ABORT  input  1: synchronous cancel of an active sequence.
REQ-007 CAPTURE  input  1: when 1 at START, append one functional-capture cycle after shifting.
REQ-008 LOAD_WORD  input  CHAIN_LEN: pattern to shift in; bit 0 shifted first.
REQ-009 SO  input  1: serial output of the last chain flop (its Q).
REQ-010 SD  output  1: mux select to chain flops (1 = scan/D1 path, 0 = functional/D0 path).
REQ-011 SP  output  1: clock enable to chain flops.
REQ-012 SI  output  1: serial data to D1 of the first chain flop.
REQ-013 BUSY  output  1: high from the cycle after START acceptance until DONE is issued.
REQ-014 DONE  output  1: one-cycle completion pulse.
REQ-015 UNLOAD_WORD  output  CHAIN_LEN: chain contents shifted out during the sequence.

Function
REQ-016 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-017 FSM states SHALL be IDLE, SHIFT, CAPT, FIN.
REQ-018 IDLE: SD=0, SP=0, BUSY=0, DONE=0; START=1 and ABORT=0 at an edge -> SHIFT; LOAD_WORD and CAPTURE latched at that same edge.
REQ-019 SHIFT: lasts exactly CHAIN_LEN cycles; SD=1, SP=1, BUSY=1; in shift cycle k (k=0..CHAIN_LEN-1), SI = latched LOAD_WORD[k].
REQ-020 In shift cycle k, SO SHALL be sampled at the closing edge into UNLOAD_WORD[k].
REQ-021 After the last shift cycle: latched CAPTURE=1 -> CAPT; otherwise -> FIN.
REQ-022 CAPT: exactly one cycle, SD=0, SP=1, SI=0, BUSY=1; then -> FIN.
REQ-023 FIN: exactly one cycle, SD=0, SP=0, BUSY=0, DONE=1; then -> IDLE.
REQ-024 The shift counter SHALL count 0..CHAIN_LEN-1 and clear on leaving SHIFT; no wrap-around within a sequence.
REQ-025 START while in SHIFT, CAPT or FIN SHALL be ignored (not queued).
REQ-026 ABORT=1 in SHIFT or CAPT -> IDLE at the next edge; DONE not asserted; UNLOAD_WORD keeps its partially updated bits.
REQ-027 START and ABORT both 1 in IDLE -> remain IDLE.
REQ-028 UNLOAD_WORD SHALL hold its value between sequences and change only during SHIFT.
REQ-029 Total latency with ABORT=0: START edge to DONE high = CHAIN_LEN+1 cycles (CAPTURE=0) or CHAIN_LEN+2 cycles (CAPTURE=1).

Reset
REQ-030 CD=1 SHALL immediately force IDLE, SD=0, SP=0, SI=0, BUSY=0, DONE=0, UNLOAD_WORD=0, counter=0, independent of CK.
REQ-031 CD asserted mid-sequence SHALL abandon the sequence; no DONE follows release.
REQ-032 After CD release, the first START is accepted at the first rising CK with CD low.

Verification
REQ-033 CHAIN_LEN=16, LOAD_WORD=16'hA5C3, CAPTURE=0, SO looped from a 16-flop model -> SI sequence 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1; DONE at cycle 17; chain holds 16'hA5C3.
REQ-034 Chain preloaded 16'h1234, LOAD_WORD=0 -> UNLOAD_WORD=16'h1234 at DONE; chain holds 16'h0000.
REQ-035 CAPTURE=1 -> exactly one cycle with SD=0, SP=1 between last shift and DONE; DONE at cycle 18.
REQ-036 ABORT pulsed in shift cycle 5 -> SD=SP=0 next cycle, BUSY=0, no DONE pulse; next START runs a full 16-cycle shift.
REQ-037 START held high continuously -> sequences back-to-back, each 16 shift cycles, with one IDLE cycle between DONE and the next SD=1.
REQ-038 CD asserted in shift cycle 8 between clock edges -> all outputs 0 immediately; UNLOAD_WORD=0; no DONE after release.

Source files
------------

// File: rtl/scan_load_ctrl.sv
// ----------------------------------------------------------------------------
// scan_load_ctrl
//   Drives a scan-mux flop chain through one load sequence. LOAD_WORD is
//   shifted in (bit 0 first) while the old chain contents arrive on SO and are
//   collected into UNLOAD_WORD. An optional functional-capture cycle can follow
//   the shift. The sequence closes with a one-cycle DONE pulse.
//
// Parameters
//   CHAIN_LEN  number of flops in the chain (2..64)
//   CNT_W      shift counter width, 2^CNT_W > CHAIN_LEN
//
// Ports
//   CK          clock, rising edge
//   CD          asynchronous active-high reset
//   START       request a load sequence (accepted only in IDLE)
//   ABORT       cancel an active shift/capture; blocks START in IDLE
//   CAPTURE     latched at START: append one capture cycle after shifting
//   LOAD_WORD   pattern to shift in, bit 0 first
//   SO          serial output of the last chain flop
//   SD          mux select (1 = scan path, 0 = functional path)
//   SP          chain clock enable
//   SI          serial data into the first chain flop
//   BUSY        sequence in progress (shift or capture)
//   DONE        one-cycle completion pulse
//   UNLOAD_WORD chain contents shifted out; bit k sampled in shift cycle k
// ----------------------------------------------------------------------------
module scan_load_ctrl #(
  parameter int CHAIN_LEN = 16,
  parameter int CNT_W     = 6
) (
  input  logic                 CK,
  input  logic                 CD,
  input  logic                 START,
  input  logic                 ABORT,
  input  logic                 CAPTURE,
  input  logic [CHAIN_LEN-1:0] LOAD_WORD,
  input  logic                 SO,
  output logic                 SD,
  output logic                 SP,
  output logic                 SI,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [CHAIN_LEN-1:0] UNLOAD_WORD
);

  typedef enum logic [1:0] {IDLE, SHIFT, CAPT, FIN} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [CHAIN_LEN-1:0] r_word;    // remaining bits to shift, next one at bit 0
  logic                 r_capt;
  logic                 r_sd;
  logic                 r_sp;
  logic                 r_si;
  logic                 r_busy;
  logic                 r_done;
  logic [CHAIN_LEN-1:0] r_unload;

  always_ff @(posedge CK or posedge CD) begin
    if (CD) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_word   <= '0;
      r_capt   <= 1'b0;
      r_sd     <= 1'b0;
      r_sp     <= 1'b0;
      r_si     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_unload <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          // ABORT alongside START keeps the controller idle.
          if (START && !ABORT) begin
            r_state <= SHIFT;
            r_cnt   <= '0;
            r_capt  <= CAPTURE;
            // Bit 0 goes straight onto SI for shift cycle 0.
            r_si    <= LOAD_WORD[0];
            r_word  <= LOAD_WORD >> 1;
            r_sd    <= 1'b1;
            r_sp    <= 1'b1;
            r_busy  <= 1'b1;
          end
        end

        SHIFT: begin
          // SP is high this cycle, so the chain shifts at this edge and SO
          // carries the bit belonging to position r_cnt.
          for (int i = 0; i < CHAIN_LEN; i++) begin
            if (r_cnt == CNT_W'(i)) r_unload[i] <= SO;
          end
          if (ABORT) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_sd    <= 1'b0;
            r_sp    <= 1'b0;
            r_si    <= 1'b0;
            r_busy  <= 1'b0;
          end else if (r_cnt == LAST_CNT) begin
            r_cnt <= '0;
            r_sd  <= 1'b0;
            r_si  <= 1'b0;
            if (r_capt) begin
              r_state <= CAPT;          // SP stays high for the capture cycle
            end else begin
              r_state <= FIN;
              r_sp    <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end else begin
            r_cnt  <= r_cnt + CNT_W'(1);
            r_si   <= r_word[0];
            r_word <= r_word >> 1;
          end
        end

        CAPT: begin
          r_sp   <= 1'b0;
          r_busy <= 1'b0;
          if (ABORT) begin
            r_state <= IDLE;
          end else begin
            r_state <= FIN;
            r_done  <= 1'b1;
          end
        end

        FIN: begin
          // START seen here is dropped; a held START is taken from IDLE.
          r_state <= IDLE;
          r_done  <= 1'b0;
        end

        default: begin
          r_state <= IDLE;
          r_sd    <= 1'b0;
          r_sp    <= 1'b0;
          r_si    <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign SD          = r_sd;
  assign SP          = r_sp;
  assign SI          = r_si;
  assign BUSY        = r_busy;
  assign DONE        = r_done;
  assign UNLOAD_WORD = r_unload;

endmodule

// File: tb/tb_scan_load_ctrl.sv
// ----------------------------------------------------------------------------
// tb_scan_load_ctrl
//   Directed bench for scan_load_ctrl with CHAIN_LEN=16. A 16-flop scan chain
//   model closes the SI -> chain -> SO loop. Inputs change and outputs are
//   sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_scan_load_ctrl;

  localparam int N = 16;

  logic         CK = 1'b0;
  logic         CD;
  logic         START;
  logic         ABORT;
  logic         CAPTURE;
  logic [N-1:0] LOAD_WORD;
  logic         SO;
  logic         SD, SP, SI, BUSY, DONE;
  logic [N-1:0] UNLOAD_WORD;

  int n_pass  = 0;
  int n_total = 0;

  // Chain model: SI enters at the top, SO is bit 0. After N scan shifts
  // chain[k] holds the k-th bit shifted in. Functional path holds its value.
  logic [N-1:0] chain;
  logic         pre_en;
  logic [N-1:0] pre_val;

  assign SO = chain[0];

  always @(posedge CK) begin
    if (pre_en)  chain <= pre_val;
    else if (SP) chain <= SD ? {SI, chain[N-1:1]} : chain;
  end

  always #5 CK = ~CK;

  scan_load_ctrl #(.CHAIN_LEN(N), .CNT_W(6)) dut (
    .CK(CK), .CD(CD), .START(START), .ABORT(ABORT), .CAPTURE(CAPTURE),
    .LOAD_WORD(LOAD_WORD), .SO(SO), .SD(SD), .SP(SP), .SI(SI), .BUSY(BUSY),
    .DONE(DONE), .UNLOAD_WORD(UNLOAD_WORD)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic preload(input logic [N-1:0] v);
    pre_en  = 1'b1;
    pre_val = v;
    @(negedge CK);
    pre_en  = 1'b0;
  endtask

  // Result of the last run_seq call.
  logic [N-1:0] r_si_bits;
  int r_nshift, r_ncapt, r_capt_cyc, r_done_cyc, r_busy_bad;

  // Issue START at a falling edge; cycle 1 is the first cycle after the
  // accepting edge. Collects observations until DONE or a 60-cycle budget.
  task automatic run_seq(input logic [N-1:0] word, input logic capt, input logic hold);
    LOAD_WORD  = word;
    CAPTURE    = capt;
    START      = 1'b1;
    r_si_bits  = '0;
    r_nshift   = 0;
    r_ncapt    = 0;
    r_capt_cyc = 0;
    r_done_cyc = 0;
    r_busy_bad = 0;
    @(negedge CK);
    if (!hold) START = 1'b0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (DONE) begin
        r_done_cyc = cyc;
        break;
      end
      if (SD && SP) begin
        if (r_nshift < N) r_si_bits[r_nshift] = SI;
        r_nshift++;
      end
      if (!SD && SP) begin
        r_ncapt++;
        r_capt_cyc = cyc;
      end
      if (!BUSY) r_busy_bad++;
      @(negedge CK);
    end
  endtask

  initial begin
    int seen_done;
    int first_sd;
    CD = 1'b1; START = 1'b0; ABORT = 1'b0; CAPTURE = 1'b0;
    LOAD_WORD = '0; pre_en = 1'b0; pre_val = '0;
    #2;
    check("rst_SD", 32'(SD), 32'd0);
    check("rst_SP", 32'(SP), 32'd0);
    check("rst_SI", 32'(SI), 32'd0);
    check("rst_BUSY", 32'(BUSY), 32'd0);
    check("rst_DONE", 32'(DONE), 32'd0);
    check("rst_UNLOAD", 32'(UNLOAD_WORD), 32'd0);
    @(negedge CK);
    CD = 1'b0;
    @(negedge CK);

    // Load A5C3 over a chain holding 1234, no capture.
    preload(16'h1234);
    run_seq(16'hA5C3, 1'b0, 1'b0);
    check("t1_si_seq", 32'(r_si_bits), 32'h0000A5C3);
    check("t1_nshift", r_nshift, 16);
    check("t1_ncapt", r_ncapt, 0);
    check("t1_done_cyc", r_done_cyc, 17);
    check("t1_busy", r_busy_bad, 0);
    check("t1_busy_at_done", 32'(BUSY), 32'd0);
    check("t1_unload", 32'(UNLOAD_WORD), 32'h00001234);
    check("t1_chain", 32'(chain), 32'h0000A5C3);
    @(negedge CK);
    check("t1_done_pulse", 32'(DONE), 32'd0);

    // Unload 1234 while loading zeros.
    preload(16'h1234);
    run_seq(16'h0000, 1'b0, 1'b0);
    check("t2_done_cyc", r_done_cyc, 17);
    check("t2_unload", 32'(UNLOAD_WORD), 32'h00001234);
    check("t2_chain", 32'(chain), 32'h00000000);
    @(negedge CK);

    // Capture cycle appended.
    run_seq(16'h00FF, 1'b1, 1'b0);
    check("t3_nshift", r_nshift, 16);
    check("t3_ncapt", r_ncapt, 1);
    check("t3_capt_cyc", r_capt_cyc, 17);
    check("t3_done_cyc", r_done_cyc, 18);
    check("t3_busy", r_busy_bad, 0);
    check("t3_si_seq", 32'(r_si_bits), 32'h000000FF);
    @(negedge CK);

    // START together with ABORT in IDLE is refused.
    START = 1'b1; ABORT = 1'b1;
    @(negedge CK);
    START = 1'b0; ABORT = 1'b0;
    check("t4_sa_SD", 32'(SD), 32'd0);
    check("t4_sa_BUSY", 32'(BUSY), 32'd0);

    // ABORT in shift cycle 5 (cycle 6).
    preload(16'hFFFF);
    LOAD_WORD = 16'h0F0F; CAPTURE = 1'b0; START = 1'b1;
    @(negedge CK);
    START = 1'b0;
    repeat (5) @(negedge CK);
    check("t4_pre_abort_SD", 32'(SD), 32'd1);
    ABORT = 1'b1;
    @(negedge CK);
    ABORT = 1'b0;
    check("t4_ab_SD", 32'(SD), 32'd0);
    check("t4_ab_SP", 32'(SP), 32'd0);
    check("t4_ab_BUSY", 32'(BUSY), 32'd0);
    check("t4_ab_low_bits", 32'(UNLOAD_WORD[4:0]), 32'h1F);
    check("t4_ab_high_bits", 32'(UNLOAD_WORD[15:6]), 32'h0);
    seen_done = 0;
    for (int i = 0; i < 20; i++) begin
      if (DONE || SD) seen_done++;
      @(negedge CK);
    end
    check("t4_no_done", seen_done, 0);
    run_seq(16'h3C5A, 1'b0, 1'b0);
    check("t4_rerun_nshift", r_nshift, 16);
    check("t4_rerun_done", r_done_cyc, 17);
    check("t4_rerun_si", 32'(r_si_bits), 32'h00003C5A);
    @(negedge CK);

    // START held high: back-to-back sequences with one idle cycle between.
    run_seq(16'h8001, 1'b0, 1'b1);
    check("t5_first_done", r_done_cyc, 17);
    @(negedge CK);
    check("t5_idle_gap_SD", 32'(SD), 32'd0);
    check("t5_idle_gap_BUSY", 32'(BUSY), 32'd0);
    @(negedge CK);
    check("t5_restart_SD", 32'(SD), 32'd1);
    first_sd = 0;
    for (int i = 0; i < 40; i++) begin
      if (DONE) break;
      if (SD && SP) first_sd++;
      @(negedge CK);
    end
    START = 1'b0;
    check("t5_second_nshift", first_sd, 16);
    check("t5_second_done", 32'(DONE), 32'd1);
    repeat (3) @(negedge CK);

    // Reset asserted between edges in shift cycle 8 (cycle 9).
    preload(16'hFFFF);
    LOAD_WORD = 16'hAAAA; START = 1'b1;
    @(negedge CK);
    START = 1'b0;
    repeat (8) @(negedge CK);
    check("t6_pre_BUSY", 32'(BUSY), 32'd1);
    check("t6_pre_unload", 32'(UNLOAD_WORD != 16'h0), 32'd1);
    #1 CD = 1'b1;
    #1;
    check("t6_SD", 32'(SD), 32'd0);
    check("t6_SP", 32'(SP), 32'd0);
    check("t6_BUSY", 32'(BUSY), 32'd0);
    check("t6_unload", 32'(UNLOAD_WORD), 32'd0);
    @(negedge CK);
    CD = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge CK);
      if (DONE || BUSY) seen_done++;
    end
    check("t6_no_done", seen_done, 0);
    run_seq(16'h1357, 1'b0, 1'b0);
    check("t6_after_done", r_done_cyc, 17);
    check("t6_after_si", 32'(r_si_bits), 32'h00001357);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
